lanes_rx_sync_lock: RTL and testbench
=====================================

# lanes_rx_sync_lock

Receive-side sync-header lock for the two USB4 lanes. It sits directly after the lane deserializer and checks the 2-bit sync header of every received parallel word on lane 0 and lane 1. When headers are misaligned it requests bit-slips until the lane is locked. While locked it monitors header errors, then forwards header-stripped payload to the descrambler only while both lanes are locked.

## Interface
Parameters:
- WIDTH, 132, received parallel word width including the 2-bit header.
- LOCK_CNT, 64, consecutive valid headers required to declare lock.
- ERR_LIMIT, 16, invalid headers within one window that drop lock.
- WINDOW, 1024, words per error-monitoring window while locked.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rst  in  1  reset, asynchronous, active-high.
- enable_dec  in  1  one-cycle strobe: lane words valid this cycle.
- gen_speed  in  2  link generation; any change forces relock.
- lane_0_rx_parallel  in  WIDTH  lane 0 received word; header in [1:0].
- lane_1_rx_parallel  in  WIDTH  lane 1 received word; header in [1:0].
- lane_0_slip  out  1  one-cycle bit-slip request to the lane 0 deserializer.
- lane_1_slip  out  1  one-cycle bit-slip request to the lane 1 deserializer.
- lane_0_locked  out  1  lane 0 in LOCKED.
- lane_1_locked  out  1  lane 1 in LOCKED.
- data_valid  out  1  payload valid strobe.
- lane_0_data  out  WIDTH-2  lane 0 payload, i.e. word[WIDTH-1:2].
- lane_1_data  out  WIDTH-2  lane 1 payload.
- sync_err_cnt  out  8  saturating count of invalid headers seen in LOCKED, summed over both lanes.

## Operation
- A header is valid if it is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
- Each lane runs an independent FSM with states HUNT, CONFIRM and LOCKED. The FSM only advances on cycles where enable_dec = 1.
- HUNT
  - Valid header: go to CONFIRM with good_cnt = 1.
  - Invalid header: pulse slip and set skip.
- skip flag: the first word strobe after a slip is ignored (no header check), and skip is then cleared.
- CONFIRM
  - Valid header: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED and clear the window counters.
  - Invalid header: pulse slip, set skip, clear good_cnt, go to HUNT.
- LOCKED
  - Every word: win_cnt++.
  - Invalid header: err_cnt++ and sync_err_cnt++ (saturates at 255).
  - When err_cnt reaches ERR_LIMIT: go to HUNT with no slip; the next invalid word in HUNT slips.
  - When win_cnt reaches WINDOW with err_cnt below the limit: clear win_cnt and err_cnt.
  - If the ERR_LIMIT-th error lands on the window's last word, lock loss takes priority.
- gen_speed change: registered gen_speed is compared each cycle. On a mismatch, both FSMs go to HUNT and every counter except sync_err_cnt is cleared. This takes priority over a same-cycle strobe, and that strobe's words are discarded.
- Payload
  - When enable_dec = 1 and both lanes are LOCKED (state before the update), register both payloads and assert data_valid.
  - Otherwise data_valid = 0; the data outputs hold their last value.
- Lanes are independent: a slip on one lane never affects the other lane's FSM.
- Reset mid-operation: everything returns to reset values immediately (asynchronous) and skip is cleared.

## Timing
- Reset values:
  - FSMs in HUNT.
  - All slip, locked and data_valid outputs are 0.
  - lane_0_data, lane_1_data and sync_err_cnt are 0.
  - Counters and skip are 0.
- Slip: pulses exactly 1 cycle, in the cycle after the offending strobe.
- Lock: lane_x_locked rises in the cycle after the LOCK_CNT-th consecutive valid strobe.
- Lock loss: lane_x_locked falls in the cycle after the ERR_LIMIT-th error strobe, or the cycle after a gen_speed change.
- Payload latency: 1 cycle; data_valid follows its enable_dec strobe by one cycle and lasts 1 cycle.
- Back-to-back strobes (enable_dec high on consecutive cycles) are legal and must all be processed.

## Structure
- Package lanes_rx_sync_pkg holds:
  - sync_state_t enum (HUNT, CONFIRM, LOCKED);
  - header constants HDR_A = 2'b01 and HDR_B = 2'b10;
  - the hdr_valid function.
- Sub-module lane_sync_fsm, instantiated once per lane, contains the FSM, good_cnt, win_cnt, err_cnt, skip, slip and locked logic.
- Top level contains the gen_speed change detect, payload registers, data_valid and the sync_err_cnt accumulator.
- Counter widths are $clog2 of the matching parameter, +1.

## Test plan
- Clean lock: after reset, 64 strobes with header 2'b01 on both lanes. Both locked signals are 1 one cycle after strobe 64, no slip occurs, and data_valid first pulses for strobe 65 with payload equal to word[131:2].
- Hunt slip: lane 0 header 2'b11 for 3 strobes, then 2'b10.
  - Strobe 1: slip one cycle later.
  - Strobe 2: ignored (skip).
  - Strobe 3: slip one cycle later.
  - Then CONFIRM. Lane 1 is unaffected throughout.
- Confirm failure: 40 valid headers, then one 2'b00. Slip pulses, the lane returns to HUNT, and lock is reached only after 64 further consecutive valid headers.
- Error window:
  - Locked lane 1 gets 15 invalid headers spread across 1024 words: it stays locked, the window clears, and sync_err_cnt = 15.
  - 16 invalid headers within one window: lane_1_locked falls one cycle after the 16th, and data_valid stops.
- gen_speed change while both lanes are locked: both locked signals fall next cycle with no slip, and sync_err_cnt is retained. Assert rst mid-CONFIRM: all outputs are 0 immediately.

Source files
------------

// File: rtl/lanes_rx_sync_pkg.sv
// lanes_rx_sync_pkg: shared sync-header types, constants and header check
package lanes_rx_sync_pkg;
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} sync_state_t;
  localparam logic [1:0] HDR_A = 2'b01;
  localparam logic [1:0] HDR_B = 2'b10;
  function automatic logic hdr_valid(input logic [1:0] hdr);
    return hdr == HDR_A || hdr == HDR_B;
  endfunction
endpackage

// File: rtl/lanes_rx_sync_lock_lane_sync_fsm.sv
// lane_sync_fsm: per-lane sync-header hunt/confirm/lock state machine
module lane_sync_fsm
  import lanes_rx_sync_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int ERR_LIMIT = 16,
  parameter int WINDOW    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [1:0] hdr_i,
  output logic       slip_o,
  output logic       locked_o,
  output logic       err_o
);
  localparam int GW = $clog2(LOCK_CNT) + 1;
  localparam int WW = $clog2(WINDOW) + 1;
  localparam int EW = $clog2(ERR_LIMIT) + 1;
  sync_state_t   state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] err_q, err_d;
  logic          skip_q, skip_d, slip_q, slip_d;
  logic          ok;
  assign ok = hdr_valid(hdr_i);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      good_q  <= '0;
      win_q   <= '0;
      err_q   <= '0;
      skip_q  <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      slip_q  <= slip_d;
    end
  end
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    err_d   = err_q;
    skip_d  = skip_q;
    slip_d  = 1'b0;
    if (clr_i) begin
      state_d = HUNT;
      good_d  = '0;
      win_d   = '0;
      err_d   = '0;
      skip_d  = 1'b0;
    end else if (en_i && skip_q) begin
      skip_d = 1'b0;
    end else if (en_i) begin
      case (state_q)
        HUNT: begin
          state_d = ok ? CONFIRM : HUNT;
          good_d  = ok ? GW'(1) : '0;
          slip_d  = !ok;
          skip_d  = !ok;
        end
        CONFIRM: begin
          if (!ok) begin
            state_d = HUNT;
            good_d  = '0;
            slip_d  = 1'b1;
            skip_d  = 1'b1;
          end else if (good_q == GW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            win_d   = '0;
            err_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          win_d = win_q + 1'b1;
          err_d = err_q + EW'(!ok);
          // lock loss wins over a window rollover on the same word
          if (err_d == EW'(ERR_LIMIT)) begin
            state_d = HUNT;
            win_d   = '0;
            err_d   = '0;
          end else if (win_d == WW'(WINDOW)) begin
            win_d = '0;
            err_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_comb begin
    locked_o = state_q == LOCKED;
    slip_o   = slip_q;
    err_o    = en_i && !clr_i && !skip_q && state_q == LOCKED && !ok;
  end
endmodule

// File: rtl/lanes_rx_sync_lock.sv
// lanes_rx_sync_lock: two-lane sync-header lock, payload forwarding and error count
module lanes_rx_sync_lock
  import lanes_rx_sync_pkg::*;
#(
  parameter int WIDTH     = 132,
  parameter int LOCK_CNT  = 64,
  parameter int ERR_LIMIT = 16,
  parameter int WINDOW    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_dec,
  input  logic [1:0]       gen_speed,
  input  logic [WIDTH-1:0] lane_0_rx_parallel,
  input  logic [WIDTH-1:0] lane_1_rx_parallel,
  output logic             lane_0_slip,
  output logic             lane_1_slip,
  output logic             lane_0_locked,
  output logic             lane_1_locked,
  output logic             data_valid,
  output logic [WIDTH-3:0] lane_0_data,
  output logic [WIDTH-3:0] lane_1_data,
  output logic [7:0]       sync_err_cnt
);
  logic [1:0]       gen_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [8:0]       cnt_sum;
  logic [WIDTH-3:0] dat0_q, dat1_q;
  logic             dv_q, chg, pay, err0, err1;
  assign chg = gen_speed != gen_q;
  assign pay = enable_dec && !chg && lane_0_locked && lane_1_locked;
  assign cnt_sum = 9'(cnt_q) + 9'(err0) + 9'(err1);
  assign cnt_d = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
  lane_sync_fsm #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW)) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .en_i     (enable_dec),
    .clr_i    (chg),
    .hdr_i    (lane_0_rx_parallel[1:0]),
    .slip_o   (lane_0_slip),
    .locked_o (lane_0_locked),
    .err_o    (err0)
  );
  lane_sync_fsm #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .en_i     (enable_dec),
    .clr_i    (chg),
    .hdr_i    (lane_1_rx_parallel[1:0]),
    .slip_o   (lane_1_slip),
    .locked_o (lane_1_locked),
    .err_o    (err1)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q  <= '0;
      cnt_q  <= '0;
      dv_q   <= 1'b0;
      dat0_q <= '0;
      dat1_q <= '0;
    end else begin
      gen_q <= gen_speed;
      cnt_q <= cnt_d;
      dv_q  <= pay;
      if (pay) begin
        dat0_q <= lane_0_rx_parallel[WIDTH-1:2];
        dat1_q <= lane_1_rx_parallel[WIDTH-1:2];
      end
    end
  end
  assign data_valid   = dv_q;
  assign lane_0_data  = dat0_q;
  assign lane_1_data  = dat1_q;
  assign sync_err_cnt = cnt_q;
endmodule

// File: tb/tb_lanes_rx_sync_lock.sv
// tb_lanes_rx_sync_lock: directed self-checking bench for lanes_rx_sync_lock
module tb_lanes_rx_sync_lock;
  logic         clk = 1'b0, rst = 1'b1, enable_dec = 1'b0;
  logic [1:0]   gen_speed = 2'b00;
  logic [131:0] w0 = '0, w1 = '0;
  logic         lane_0_slip, lane_1_slip, lane_0_locked, lane_1_locked, data_valid;
  logic [129:0] lane_0_data, lane_1_data;
  logic [7:0]   sync_err_cnt;
  logic [129:0] p0 = '0, p1 = '0;
  int           total = 0, bad = 0;
  wire  [4:0]   st = {lane_0_locked, lane_1_locked, lane_0_slip, lane_1_slip, data_valid};
  lanes_rx_sync_lock dut (
    .clk                (clk),
    .rst                (rst),
    .enable_dec         (enable_dec),
    .gen_speed          (gen_speed),
    .lane_0_rx_parallel (w0),
    .lane_1_rx_parallel (w1),
    .lane_0_slip        (lane_0_slip),
    .lane_1_slip        (lane_1_slip),
    .lane_0_locked      (lane_0_locked),
    .lane_1_locked      (lane_1_locked),
    .data_valid         (data_valid),
    .lane_0_data        (lane_0_data),
    .lane_1_data        (lane_1_data),
    .sync_err_cnt       (sync_err_cnt)
  );
  always #5 clk = ~clk;
  // st = {locked0, locked1, slip0, slip1, data_valid}, sampled at the negedge after the strobe
  task automatic cyc(input logic en, input logic [1:0] h0, input logic [1:0] h1);
    enable_dec = en;
    w0 = {p0, h0};
    w1 = {p1, h1};
    @(negedge clk);
    enable_dec = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    gen_speed = 2'b00;
    enable_dec = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL reset_st got=%b exp=%b", st, 5'b00000); end
    total++; if (lane_0_data !== '0 || lane_1_data !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", lane_0_data, lane_1_data); end
    total++; if (sync_err_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", sync_err_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_clean_lock();
    logic [129:0] e0;
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      cyc(1'b1, 2'b01, 2'b01);
      total++; if (st !== (i == 64 ? 5'b11000 : 5'b00000)) begin bad++; $display("FAIL clean_lock_%0d got=%b exp=%b", i, st, (i == 64 ? 5'b11000 : 5'b00000)); end
    end
    p0 = {2'b01, 128'hdeadbeef_01234567_89abcdef_00112233};
    p1 = {2'b10, 128'hcafef00d_76543210_fedcba98_44556677};
    cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b11001) begin bad++; $display("FAIL payload_st got=%b exp=%b", st, 5'b11001); end
    total++; if (lane_0_data !== p0) begin bad++; $display("FAIL payload0 got=%h exp=%h", lane_0_data, p0); end
    total++; if (lane_1_data !== p1) begin bad++; $display("FAIL payload1 got=%h exp=%h", lane_1_data, p1); end
    e0 = p0;
    p0 = ~p0;
    cyc(1'b0, 2'b01, 2'b01);
    total++; if (st !== 5'b11000) begin bad++; $display("FAIL idle_st got=%b exp=%b", st, 5'b11000); end
    total++; if (lane_0_data !== e0) begin bad++; $display("FAIL data_hold got=%h exp=%h", lane_0_data, e0); end
  endtask
  task automatic test_hunt_slip();
    logic [1:0] hs [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
    logic [4:0] es [4] = '{5'b00100, 5'b00000, 5'b00100, 5'b00000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, hs[i], 2'b01);
      total++; if (st !== es[i]) begin bad++; $display("FAIL hunt_strobe%0d got=%b exp=%b", i + 1, st, es[i]); end
    end
    // the 2'b10 word follows a slip and is skipped, so lane 0 confirms from strobe 5
    repeat (63) cyc(1'b1, 2'b10, 2'b01);
    total++; if (st !== 5'b01000) begin bad++; $display("FAIL hunt_pre_lock got=%b exp=%b", st, 5'b01000); end
    cyc(1'b1, 2'b10, 2'b01);
    total++; if (st !== 5'b11000) begin bad++; $display("FAIL hunt_lock got=%b exp=%b", st, 5'b11000); end
  endtask
  task automatic test_confirm_fail();
    do_reset();
    repeat (40) cyc(1'b1, 2'b01, 2'b01);
    cyc(1'b1, 2'b00, 2'b01);
    total++; if (st !== 5'b00100) begin bad++; $display("FAIL confirm_slip got=%b exp=%b", st, 5'b00100); end
    repeat (64) cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b01000) begin bad++; $display("FAIL confirm_pre_lock got=%b exp=%b", st, 5'b01000); end
    cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b11000) begin bad++; $display("FAIL confirm_relock got=%b exp=%b", st, 5'b11000); end
  endtask
  task automatic test_err_window();
    do_reset();
    repeat (64) cyc(1'b1, 2'b01, 2'b01);
    for (int i = 1; i <= 1024; i++)
      cyc(1'b1, 2'b01, (i % 64 == 0 && i <= 960) ? 2'b00 : 2'b01);
    total++; if (st !== 5'b11001) begin bad++; $display("FAIL window15_st got=%b exp=%b", st, 5'b11001); end
    total++; if (sync_err_cnt !== 8'd15) begin bad++; $display("FAIL window15_cnt got=%0d exp=15", sync_err_cnt); end
    repeat (15) cyc(1'b1, 2'b10, 2'b11);
    total++; if (st !== 5'b11001) begin bad++; $display("FAIL window_clear_st got=%b exp=%b", st, 5'b11001); end
    total++; if (sync_err_cnt !== 8'd30) begin bad++; $display("FAIL window_clear_cnt got=%0d exp=30", sync_err_cnt); end
    cyc(1'b1, 2'b10, 2'b11);
    total++; if (st !== 5'b10001) begin bad++; $display("FAIL err16_st got=%b exp=%b", st, 5'b10001); end
    total++; if (sync_err_cnt !== 8'd31) begin bad++; $display("FAIL err16_cnt got=%0d exp=31", sync_err_cnt); end
    cyc(1'b1, 2'b10, 2'b11);
    total++; if (st !== 5'b10010) begin bad++; $display("FAIL post_loss_slip got=%b exp=%b", st, 5'b10010); end
    total++; if (sync_err_cnt !== 8'd31) begin bad++; $display("FAIL post_loss_cnt got=%0d exp=31", sync_err_cnt); end
  endtask
  task automatic test_gen_speed();
    logic [129:0] a;
    do_reset();
    repeat (64) cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b11000) begin bad++; $display("FAIL gen_lock got=%b exp=%b", st, 5'b11000); end
    p0 = {2'b11, 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0};
    a = p0;
    cyc(1'b1, 2'b11, 2'b01);
    total++; if (st !== 5'b11001 || lane_0_data !== a) begin bad++; $display("FAIL gen_payload got=%b/%h exp=%b/%h", st, lane_0_data, 5'b11001, a); end
    cyc(1'b1, 2'b00, 2'b01);
    total++; if (sync_err_cnt !== 8'd2) begin bad++; $display("FAIL gen_errs got=%0d exp=2", sync_err_cnt); end
    gen_speed = 2'b01;
    p0 = ~a;
    cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL gen_drop got=%b exp=%b", st, 5'b00000); end
    total++; if (lane_0_data !== a) begin bad++; $display("FAIL gen_discard got=%h exp=%h", lane_0_data, a); end
    total++; if (sync_err_cnt !== 8'd2) begin bad++; $display("FAIL gen_cnt_kept got=%0d exp=2", sync_err_cnt); end
    cyc(1'b0, 2'b01, 2'b01);
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL gen_no_slip got=%b exp=%b", st, 5'b00000); end
    repeat (63) cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL gen_pre_relock got=%b exp=%b", st, 5'b00000); end
    cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b11000) begin bad++; $display("FAIL gen_relock got=%b exp=%b", st, 5'b11000); end
  endtask
  task automatic test_reset_mid();
    gen_speed = 2'b10;
    cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL mid_gen_drop got=%b exp=%b", st, 5'b00000); end
    repeat (10) cyc(1'b1, 2'b01, 2'b01);
    cyc(1'b1, 2'b00, 2'b01);
    total++; if (st !== 5'b00100) begin bad++; $display("FAIL mid_confirm_slip got=%b exp=%b", st, 5'b00100); end
    #2 rst = 1'b1;
    #1;
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL async_rst_st got=%b exp=%b", st, 5'b00000); end
    total++; if (lane_0_data !== '0 || lane_1_data !== '0 || sync_err_cnt !== 8'd0) begin bad++; $display("FAIL async_rst_regs got=%h/%h/%0d exp=0", lane_0_data, lane_1_data, sync_err_cnt); end
    gen_speed = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (63) cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b00000) begin bad++; $display("FAIL rst_skip_pre got=%b exp=%b", st, 5'b00000); end
    cyc(1'b1, 2'b01, 2'b01);
    total++; if (st !== 5'b11000) begin bad++; $display("FAIL rst_skip_cleared got=%b exp=%b", st, 5'b11000); end
  endtask
  initial begin
    test_reset();
    test_clean_lock();
    test_hunt_slip();
    test_confirm_fail();
    test_err_window();
    test_gen_speed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
